ast_channel_mux: RTL

AST_CHANNEL_MUX -- requirements
Module: ast_channel_mux

---
 rtl/ast_channel_mux.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ast_channel_mux.sv
// Avalon-ST channel selector with glitch-free mute on switch and a two-stage
// shift/requantise datapath that saturates or wraps and counts overflows.
`timescale 1ns/1ps
module ast_channel_mux #(
  parameter  int N_CH       = 4,
  parameter  int IN_W       = 31,
  parameter  int OUT_W      = 12,
  parameter  int SHIFT      = 18,
  parameter  int SAT_EN     = 1,
  parameter  int MUTE_BEATS = 4,
  localparam int SEL_W      = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_CH*IN_W-1:0] ast_sink_data,
  input  logic [N_CH-1:0]      ast_sink_valid,
  input  logic [2*N_CH-1:0]    ast_sink_error,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 clr_stats,
  output logic [OUT_W-1:0]     ast_source_data,
  output logic                 ast_source_valid,
  output logic [1:0]           ast_source_error,
  output logic [SEL_W-1:0]     active_sel,
  output logic                 muting,
  output logic [15:0]          sat_count
);

  typedef enum logic {RUN = 1'b0, MUTE = 1'b1} state_t;

  localparam logic [SEL_W:0]   N_CH_L    = (SEL_W+1)'(N_CH);
  localparam logic [7:0]       MUTE_INIT = 8'(MUTE_BEATS);
  localparam logic [OUT_W-1:0] MAX_L     = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN_L     = {1'b1, {(OUT_W-1){1'b0}}};

  state_t                 state_r;
  logic [7:0]             mute_cnt_r;
  logic [SEL_W-1:0]       active_sel_r;
  logic                   muting_r;

  logic [IN_W-1:0]        sel_data_s;
  logic [1:0]             sel_err_s;
  logic                   sel_valid_s;
  logic signed [IN_W-1:0] shifted_s;
  logic                   switch_req_s;
  logic                   accept_s;

  logic                   s1_valid_r;
  logic signed [IN_W-1:0] s1_data_r;
  logic [1:0]             s1_err_r;
  logic                   s1_mute_r;

  logic [OUT_W-1:0]       out_s;
  logic                   ovf_s;

  logic [OUT_W-1:0]       src_data_r;
  logic                   src_valid_r;
  logic [1:0]             src_err_r;
  logic [15:0]            sat_count_r;

  // In range only when every bit above the output sign bit matches it.
  function automatic logic is_ovf(input logic signed [IN_W-1:0] v);
    logic [IN_W-OUT_W:0] upper;
    upper = v[IN_W-1:OUT_W-1];
    return !((&upper) || (~|upper));
  endfunction

  function automatic logic [OUT_W-1:0] requant(input logic signed [IN_W-1:0] v);
    logic [OUT_W-1:0] res;
    if (is_ovf(v) && (SAT_EN != 0)) begin
      res = v[IN_W-1] ? MIN_L : MAX_L;
    end else begin
      res = v[OUT_W-1:0];
    end
    return res;
  endfunction

  // Route the currently active channel onto the capture stage.
  always_comb begin
    sel_data_s  = '0;
    sel_err_s   = 2'b00;
    sel_valid_s = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      sel_data_s  = (active_sel_r == SEL_W'(k)) ? ast_sink_data[k*IN_W +: IN_W] : sel_data_s;
      sel_err_s   = (active_sel_r == SEL_W'(k)) ? ast_sink_error[2*k +: 2]      : sel_err_s;
      sel_valid_s = (active_sel_r == SEL_W'(k)) ? ast_sink_valid[k]             : sel_valid_s;
    end
    shifted_s    = $signed(sel_data_s) >>> SHIFT;
    accept_s     = sel_valid_s;
    switch_req_s = (sel != active_sel_r) && ({1'b0, sel} < N_CH_L);
  end

  // Channel switch / mute FSM; a switch always wins over mute countdown.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= MUTE;
      mute_cnt_r   <= MUTE_INIT;
      active_sel_r <= '0;
      muting_r     <= 1'b1;
    end else if (switch_req_s) begin
      state_r      <= MUTE;
      mute_cnt_r   <= MUTE_INIT;
      active_sel_r <= sel;
      muting_r     <= 1'b1;
    end else if (accept_s && (state_r == MUTE)) begin
      mute_cnt_r <= mute_cnt_r - 8'd1;
      if (mute_cnt_r == 8'd1) begin
        state_r  <= RUN;
        muting_r <= 1'b0;
      end
    end
  end

  // Stage 2 selection: muted or errored beats carry zero and never count.
  always_comb begin
    out_s = '0;
    ovf_s = 1'b0;
    if (s1_mute_r || (s1_err_r != 2'b00)) begin
      out_s = '0;
      ovf_s = 1'b0;
    end else begin
      out_s = requant(s1_data_r);
      ovf_s = is_ovf(s1_data_r);
    end
  end

  // Capture/shift stage followed by the registered source outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_r  <= 1'b0;
      s1_data_r   <= '0;
      s1_err_r    <= 2'b00;
      s1_mute_r   <= 1'b0;
      src_valid_r <= 1'b0;
      src_data_r  <= '0;
      src_err_r   <= 2'b00;
      sat_count_r <= 16'h0000;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_data_r <= shifted_s;
        s1_err_r  <= sel_err_s;
        s1_mute_r <= (state_r == MUTE) || switch_req_s;
      end
      src_valid_r <= s1_valid_r;
      src_data_r  <= s1_valid_r ? out_s : '0;
      src_err_r   <= s1_valid_r ? s1_err_r : 2'b00;
      if (clr_stats) begin
        sat_count_r <= 16'h0000;
      end else if (s1_valid_r && ovf_s && (sat_count_r != 16'hFFFF)) begin
        sat_count_r <= sat_count_r + 16'd1;
      end
    end
  end

  assign ast_source_data  = src_data_r;
  assign ast_source_valid = src_valid_r;
  assign ast_source_error = src_err_r;
  assign active_sel       = active_sel_r;
  assign muting           = muting_r;
  assign sat_count        = sat_count_r;

endmodule
